// File: rtl/xsw_rr_pkt_arbiter_if.sv
// Request/grant bundle between input-port request logic and one switch output.
// master = requester side, slave = arbiter side.
interface xsw_rr_pkt_arbiter_if #(
  parameter int NREQ = 8,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_last;
  logic            out_rdy;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_vld;
  logic            xfer_last;
  logic            err_tmo;

  modport master (
    output req, req_last, out_rdy,
    input  gnt, gnt_id, gnt_vld, xfer_last, err_tmo
  );

  modport slave (
    input  req, req_last, out_rdy,
    output gnt, gnt_id, gnt_vld, xfer_last, err_tmo
  );
endinterface

// File: rtl/xsw_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter for one switch output port.
// Define XSW_ARB_TMO_EN to enable the lock-stall timeout (force release + err_tmo pulse).
module xsw_rr_pkt_arbiter #(
  parameter int NREQ    = 8,
  parameter int IDW     = $clog2(NREQ),
  parameter int TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  xsw_rr_pkt_arbiter_if.slave arb
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;

  logic [NREQ-1:0] masked;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  gnt_id_c;
  logic            gnt_vld_c;
  logic [NREQ-1:0] gnt_c;
  logic            xfer;
  logic            xfer_last_c;
  logic            tmo_hit;
  logic            err_tmo_c;

  // Prefix-OR of onehot(p): every bit at or above the pointer is set.
  function automatic logic [NREQ-1:0] thermo_mask(input logic [IDW-1:0] p);
    logic [NREQ-1:0] m;
    logic            acc;
    acc = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      acc  = acc | (IDW'(i) == p);
      m[i] = acc;
    end
    return m;
  endfunction

  function automatic logic [IDW-1:0] lowest_idx(input logic [NREQ-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (IDW'(i) == idx);
    end
    return v;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    if (id == IDW'(NREQ - 1)) return '0;
    return id + IDW'(1);
  endfunction

  assign masked = arb.req & thermo_mask(ptr_q);
  assign pick   = (|masked) ? lowest_idx(masked) : lowest_idx(arb.req);

  always_comb begin
    gnt_id_c  = '0;
    gnt_vld_c = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_id_c  = pick;
        gnt_vld_c = |arb.req;
      end
      LOCK: begin
        gnt_id_c  = lock_id_q;
        gnt_vld_c = arb.req[lock_id_q];
      end
      default: begin
        gnt_id_c  = '0;
        gnt_vld_c = 1'b0;
      end
    endcase
    // While locked the grant stays asserted even if the owner drops req.
    gnt_c       = ((state_q == LOCK) || gnt_vld_c) ? onehot(gnt_id_c) : '0;
    xfer        = gnt_vld_c & arb.out_rdy;
    xfer_last_c = xfer & arb.req_last[gnt_id_c];
  end

`ifdef XSW_ARB_TMO_EN
  localparam int CNT_W = (TMO_CYC > 255) ? 16 : 8;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic             err_tmo_q;

  // Counter is held at zero outside LOCK, which also clears it on lock entry.
  always_comb begin
    stall_d = '0;
    tmo_hit = 1'b0;
    if (state_q == LOCK) begin
      if (xfer) begin
        stall_d = '0;
      end else begin
        stall_d = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
        tmo_hit = (stall_d >= TMO_LIM);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      err_tmo_q <= tmo_hit;
    end
  end

  assign err_tmo_c = err_tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TMO_CYC > 0);
  assign tmo_hit        = 1'b0;
  assign err_tmo_c      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: begin
        if (xfer_last_c) begin
          ptr_d = next_ptr(pick);
        end else if (gnt_vld_c) begin
          state_d   = LOCK;
          lock_id_d = pick;
        end
      end
      LOCK: begin
        if (xfer_last_c || tmo_hit) begin
          state_d = IDLE;
          ptr_d   = next_ptr(lock_id_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Outputs are forced low while reset is held so a pending req cannot leak a grant.
  assign arb.gnt       = rst_n ? gnt_c       : '0;
  assign arb.gnt_id    = rst_n ? gnt_id_c    : '0;
  assign arb.gnt_vld   = rst_n ? gnt_vld_c   : 1'b0;
  assign arb.xfer_last = rst_n ? xfer_last_c : 1'b0;
  assign arb.err_tmo   = err_tmo_c;

endmodule

// File: tb/tb_xsw_rr_pkt_arbiter.sv
// Bench for xsw_rr_pkt_arbiter (NREQ=4): directed scenarios plus a randomized run
// against a circular-search reference model.
module tb_xsw_rr_pkt_arbiter;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  xsw_rr_pkt_arbiter_if #(.NREQ(N), .IDW(2)) arb ();

  xsw_rr_pkt_arbiter #(.NREQ(N), .IDW(2), .TMO_CYC(TMO)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_stall;
  bit m_err;

  function automatic logic [7:0] pack_out();
    return {arb.gnt, arb.gnt_id, arb.gnt_vld, arb.xfer_last};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    arb.req      = r;
    arb.req_last = l;
    arb.out_rdy  = rdy;
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_stall  = 0;
    m_err    = 1'b0;
  endtask

  task automatic apply_reset();
    drive(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  // Expected outputs: scan requesters circularly starting at the pointer.
  task automatic model_eval(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                            output int win, output logic [7:0] e);
    int   id;
    bit   v;
    bit   xl;
    logic [3:0] g;
    if (!m_locked) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      v  = (win >= 0);
      id = v ? win : 0;
      g  = v ? 4'(1 << win) : 4'b0000;
    end else begin
      win = m_owner;
      id  = m_owner;
      v   = r[m_owner];
      g   = 4'(1 << m_owner);
    end
    xl = v && rdy && l[id];
    e  = {g, 2'(id), v, xl};
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    int         win;
    logic [7:0] e;
    bit         nerr;
    model_eval(r, l, rdy, win, e);
    nerr = 1'b0;
    if (!m_locked) begin
      if (e[1]) begin
        if (e[0]) m_ptr = (win + 1) % N;
        else begin
          m_locked = 1'b1;
          m_owner  = win;
          m_stall  = 0;
        end
      end
    end else if (e[0]) begin
      m_locked = 1'b0;
      m_ptr    = (m_owner + 1) % N;
    end else begin
`ifdef XSW_ARB_TMO_EN
      if (e[1] && rdy) m_stall = 0;
      else begin
        m_stall++;
        if (m_stall >= TMO) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % N;
          nerr     = 1'b1;
        end
      end
`endif
    end
    m_err = nerr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1);
    #2;
    n_tests++;
    if ({pack_out(), arb.err_tmo} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected %b", {pack_out(), arb.err_tmo}, 9'b0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    n_tests++;
    if ({pack_out(), arb.err_tmo} !== 9'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got %b, expected %b", {pack_out(), arb.err_tmo}, 9'b0);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_o;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      @(negedge clk);
      exp_o = {4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b1};
      n_tests++;
      if (pack_out() !== exp_o) begin
        n_fail++;
        $display("FAIL rr_grant cyc%0d: got %b, expected %b", k, pack_out(), exp_o);
      end
      tick();
    end
  endtask

  task automatic test_multi_beat();
    logic [3:0] r  [0:3];
    logic [3:0] l  [0:3];
    logic [7:0] eo [0:3];
    r  = '{4'b0101, 4'b0101, 4'b0101, 4'b0100};
    l  = '{4'b0000, 4'b0000, 4'b0001, 4'b0100};
    eo = '{8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0001_00_1_1, 8'b0100_10_1_1};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(r[k], l[k], 1'b1);
      @(negedge clk);
      n_tests++;
      if (pack_out() !== eo[k]) begin
        n_fail++;
        $display("FAIL multi_beat cyc%0d: got %b, expected %b", k, pack_out(), eo[k]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    apply_reset();
    drive(4'b0001, 4'b0001, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      @(negedge clk);
      n_tests++;
      if (pack_out() !== 8'b0010_01_1_0) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d: got %b, expected %b", k, pack_out(), 8'b0010_01_1_0);
      end
      tick();
    end
    drive(4'b1111, 4'b1111, 1'b1);
    @(negedge clk);
    n_tests++;
    if (pack_out() !== 8'b0010_01_1_1) begin
      n_fail++;
      $display("FAIL stall_release: got %b, expected %b", pack_out(), 8'b0010_01_1_1);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (pack_out() !== 8'b0100_10_1_1) begin
      n_fail++;
      $display("FAIL stall_next_grant: got %b, expected %b", pack_out(), 8'b0100_10_1_1);
    end
    tick();
  endtask

  task automatic test_req_drop();
    logic [3:0] r  [0:4];
    logic [3:0] l  [0:4];
    logic [7:0] eo [0:4];
    r  = '{4'b0010, 4'b1101, 4'b1101, 4'b1111, 4'b1101};
    l  = '{4'b0000, 4'b1111, 4'b1111, 4'b0010, 4'b1111};
    eo = '{8'b0010_01_1_0, 8'b0010_01_0_0, 8'b0010_01_0_0, 8'b0010_01_1_1, 8'b0100_10_1_1};
    apply_reset();
    drive(4'b0001, 4'b0001, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(r[k], l[k], 1'b1);
      @(negedge clk);
      n_tests++;
      if (pack_out() !== eo[k]) begin
        n_fail++;
        $display("FAIL req_drop cyc%0d: got %b, expected %b", k, pack_out(), eo[k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      drive(4'b1000, 4'b0000, 1'b1);
      @(negedge clk);
      n_tests++;
      if (pack_out() !== 8'b1000_11_1_0) begin
        n_fail++;
        $display("FAIL lock_req3 cyc%0d: got %b, expected %b", k, pack_out(), 8'b1000_11_1_0);
      end
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pack_out(), arb.err_tmo} !== 9'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b, expected %b", {pack_out(), arb.err_tmo}, 9'b0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'b1000, 4'b1000, 1'b1);
    @(negedge clk);
    n_tests++;
    if (pack_out() !== 8'b1000_11_1_1) begin
      n_fail++;
      $display("FAIL post_reset_grant: got %b, expected %b", pack_out(), 8'b1000_11_1_1);
    end
    tick();
    drive(4'b0011, 4'b0011, 1'b1);
    @(negedge clk);
    n_tests++;
    if (pack_out() !== 8'b0001_00_1_1) begin
      n_fail++;
      $display("FAIL ptr_wrap: got %b, expected %b", pack_out(), 8'b0001_00_1_1);
    end
    tick();
  endtask

`ifdef XSW_ARB_TMO_EN
  task automatic test_timeout();
    apply_reset();
    drive(4'b0001, 4'b0000, 1'b0);
    tick();
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      n_tests++;
      if ({pack_out(), arb.err_tmo} !== {8'b0001_00_1_0, 1'b0}) begin
        n_fail++;
        $display("FAIL tmo_locked cyc%0d: got %b, expected %b", k,
                 {pack_out(), arb.err_tmo}, {8'b0001_00_1_0, 1'b0});
      end
      tick();
    end
    drive(4'b0011, 4'b0011, 1'b1);
    @(negedge clk);
    n_tests++;
    if ({pack_out(), arb.err_tmo} !== {8'b0010_01_1_1, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_release: got %b, expected %b", {pack_out(), arb.err_tmo},
               {8'b0010_01_1_1, 1'b1});
    end
    tick();
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    n_tests++;
    if (arb.err_tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pulse_width: got %b, expected 0", arb.err_tmo);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] l;
    logic       rdy;
    logic [7:0] e;
    int         win;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      r   = 4'($urandom_range(0, 15));
      l   = 4'($urandom_range(0, 15));
      rdy = (k % 100 < 70) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      drive(r, l, rdy);
      @(negedge clk);
      model_eval(r, l, rdy, win, e);
      n_tests++;
      if ({pack_out(), arb.err_tmo} !== {e, m_err}) begin
        n_fail++;
        $display("FAIL random cyc%0d req=%b last=%b rdy=%b: got %b, expected %b",
                 k, r, l, rdy, {pack_out(), arb.err_tmo}, {e, m_err});
      end
      model_step(r, l, rdy);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_multi_beat();
    test_stall();
    test_req_drop();
    test_reset_mid_packet();
`ifdef XSW_ARB_TMO_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
